hbif_uart_tx: RTL and testbench

- Byte-serial UART transmitter for the host bus interface; drives the pad-side serial line (uio_out[4] at top level).
- Accepts bytes from the interface core over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as 8N1 (LSB first) at a fixed clocks-per-bit rate.
- Companion to the receive path on uio_in[3].

---
 rtl/hbif_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_hbif_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbif_uart_tx.sv
// Host bus interface UART transmitter: FIFO-buffered 8N1 serializer with valid/ready input.
// Define HBIF_UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module hbif_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]     DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef HBIF_UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     baud_q, baud_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef HBIF_UART_TX_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_q, rdPtr_q;
    logic [AW:0]     count_q;
    logic            push, pop, empty, startFrame;

    assign empty   = (count_q == '0);
    assign ready_o = (count_q != DEPTH_CNT);
    assign push    = valid_i && ready_o;
    assign tx_o    = tx_q;
    assign level_o = count_q;
    assign busy_o  = (state_q != S_IDLE) || !empty;

    // tx_d is the line level for the next cycle, so every transition sets it explicitly.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        startFrame = 1'b0;
`ifdef HBIF_UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d       = 1'b1;
                startFrame = !empty && en_i;
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    state_d  = S_DATA;
                    baud_d   = BAUD_MAX;
                    bitIdx_d = 3'd0;
                    tx_d     = shift_q[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = BAUD_MAX;
                    if (bitIdx_q == 3'd7) begin
`ifdef HBIF_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        tx_d     = shift_q[1];
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`ifdef HBIF_UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_q == 16'd0) begin
                    state_d = S_STOP;
                    baud_d  = BAUD_MAX;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (baud_q == 16'd0) begin
                    state_d    = S_IDLE;
                    tx_d       = 1'b1;
                    startFrame = !empty && en_i;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Shared by IDLE and the final STOP cycle so back-to-back frames need no idle gap.
        if (startFrame) begin
            state_d = S_START;
            baud_d  = BAUD_MAX;
            shift_d = mem_q[rdPtr_q];
            tx_d    = 1'b0;
`ifdef HBIF_UART_TX_PARITY_EN
            parity_d = ^mem_q[rdPtr_q];
`endif
        end
    end

    assign pop = startFrame;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            baud_q   <= 16'd0;
            bitIdx_q <= 3'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
`ifdef HBIF_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef HBIF_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
            if (push) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: tb/tb_hbif_uart_tx.sv
// Directed self-checking bench for hbif_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_hbif_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef HBIF_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      en_i;
    logic [7:0]                data_i;
    logic                      valid_i;
    logic                      ready_o;
    logic                      tx_o;
    logic                      busy_o;
    logic [$clog2(DEPTH):0]    level_o;

    int compared   = 0;
    int mismatched = 0;

    hbif_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .level_o (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Expected frame, index 0 = start bit, transmitted LSB first.
    function automatic logic [FRAME_BITS-1:0] mk_frame(input logic [7:0] b);
`ifdef HBIF_UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic seen;
        int   guard;
        guard   = 0;
        data_i  = b;
        valid_i = 1'b1;
        do begin
            seen = ready_o;
            tick(1);
            guard++;
        end while (!seen && guard < 100);
        valid_i = 1'b0;
    endtask

    // Waits for the start bit (bounded), then samples every bit centre; waited=-1 on timeout.
    task automatic capture_frame(input int timeout, output logic [FRAME_BITS-1:0] bits, output int waited);
        waited = 0;
        bits   = '0;
        while (tx_o !== 1'b0 && waited < timeout) begin
            tick(1);
            waited++;
        end
        if (tx_o !== 1'b0) begin
            waited = -1;
            return;
        end
        tick(CPB / 2);
        bits[0] = tx_o;
        for (int i = 1; i < FRAME_BITS; i++) begin
            tick(CPB);
            bits[i] = tx_o;
        end
    endtask

    task automatic test_reset();
        int lows;
        rst_i = 1'b1;
        tick(3);
        compared++; if (tx_o !== 1'b1)    begin mismatched++; $display("[TB] FAIL reset_tx got=%b exp=1", tx_o); end
        compared++; if (level_o !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_level got=%0d exp=0", level_o); end
        compared++; if (busy_o !== 1'b0)  begin mismatched++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); end
        compared++; if (ready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready got=%b exp=1", ready_o); end
        rst_i = 1'b0;
        tick(2);
        push_byte(8'h0F);
        push_byte(8'hF0);
        tick(10);
        rst_i = 1'b1;
        tick(1);
        compared++; if (tx_o !== 1'b1)    begin mismatched++; $display("[TB] FAIL midreset_tx got=%b exp=1", tx_o); end
        compared++; if (level_o !== 3'd0) begin mismatched++; $display("[TB] FAIL midreset_level got=%0d exp=0", level_o); end
        compared++; if (busy_o !== 1'b0)  begin mismatched++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy_o); end
        compared++; if (ready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_ready got=%b exp=1", ready_o); end
        tick(2);
        rst_i = 1'b0;
        lows  = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (tx_o !== 1'b1) lows++;
        end
        compared++; if (lows !== 0)       begin mismatched++; $display("[TB] FAIL postreset_quiet got=%0d low cycles exp=0", lows); end
        compared++; if (busy_o !== 1'b0)  begin mismatched++; $display("[TB] FAIL postreset_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_single();
        logic [FRAME_BITS-1:0] bits;
        int w;
        push_byte(8'hA5);
        capture_frame(200, bits, w);
        compared++; if (w !== 1)                    begin mismatched++; $display("[TB] FAIL single_latency got=%0d exp=1", w); end
        compared++; if (bits !== mk_frame(8'hA5))   begin mismatched++; $display("[TB] FAIL single_frame got=%b exp=%b", bits, mk_frame(8'hA5)); end
        tick(1);
        compared++; if (busy_o !== 1'b1)            begin mismatched++; $display("[TB] FAIL single_busy_last got=%b exp=1", busy_o); end
        tick(1);
        compared++; if (busy_o !== 1'b0)            begin mismatched++; $display("[TB] FAIL single_busy_drop got=%b exp=0", busy_o); end
        compared++; if (tx_o !== 1'b1)              begin mismatched++; $display("[TB] FAIL single_idle_tx got=%b exp=1", tx_o); end
    endtask

    task automatic test_fill();
        logic [FRAME_BITS-1:0] bits;
        int w;
        en_i    = 1'b0;
        valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_i = 8'(i);
            tick(1);
        end
        compared++; if (level_o !== 3'd4) begin mismatched++; $display("[TB] FAIL fill_level got=%0d exp=4", level_o); end
        compared++; if (ready_o !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_ready got=%b exp=0", ready_o); end
        data_i = 8'h05;
        tick(3);
        compared++; if (level_o !== 3'd4) begin mismatched++; $display("[TB] FAIL fill_fifth_waits got=%0d exp=4", level_o); end
        en_i = 1'b1;
        tick(1);
        compared++; if (tx_o !== 1'b0)    begin mismatched++; $display("[TB] FAIL fill_start got=%b exp=0", tx_o); end
        compared++; if (level_o !== 3'd3) begin mismatched++; $display("[TB] FAIL fill_pop_level got=%0d exp=3", level_o); end
        compared++; if (ready_o !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_slot_freed got=%b exp=1", ready_o); end
        fork
            capture_frame(200, bits, w);
            begin
                tick(1);
                compared++; if (level_o !== 3'd4) begin mismatched++; $display("[TB] FAIL fill_refill got=%0d exp=4", level_o); end
                valid_i = 1'b0;
            end
        join
        compared++; if (w !== 0)                  begin mismatched++; $display("[TB] FAIL fill_gap_1 got=%0d exp=0", w); end
        compared++; if (bits !== mk_frame(8'h01)) begin mismatched++; $display("[TB] FAIL fill_frame_1 got=%b exp=%b", bits, mk_frame(8'h01)); end
        for (int i = 2; i <= 5; i++) begin
            capture_frame(200, bits, w);
            compared++; if (w !== 2)                     begin mismatched++; $display("[TB] FAIL fill_gap_%0d got=%0d exp=2", i, w); end
            compared++; if (bits !== mk_frame(8'(i)))    begin mismatched++; $display("[TB] FAIL fill_frame_%0d got=%b exp=%b", i, bits, mk_frame(8'(i))); end
        end
        tick(1);
        compared++; if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_busy_last got=%b exp=1", busy_o); end
        tick(1);
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_busy_drop got=%b exp=0", busy_o); end
    endtask

    task automatic test_enable();
        logic [FRAME_BITS-1:0] bits;
        int w;
        int lows;
        en_i = 1'b0;
        push_byte(8'h3C);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (tx_o !== 1'b1) lows++;
        end
        compared++; if (lows !== 0)       begin mismatched++; $display("[TB] FAIL en_gated_quiet got=%0d low cycles exp=0", lows); end
        compared++; if (level_o !== 3'd1) begin mismatched++; $display("[TB] FAIL en_gated_level got=%0d exp=1", level_o); end
        push_byte(8'h55);
        compared++; if (level_o !== 3'd2) begin mismatched++; $display("[TB] FAIL en_push_while_off got=%0d exp=2", level_o); end
        en_i = 1'b1;
        tick(1);
        compared++; if (tx_o !== 1'b0)    begin mismatched++; $display("[TB] FAIL en_start_latency got=%b exp=0", tx_o); end
        fork
            capture_frame(200, bits, w);
            begin
                tick(10);
                en_i = 1'b0;
            end
        join
        compared++; if (bits !== mk_frame(8'h3C)) begin mismatched++; $display("[TB] FAIL en_frame_completes got=%b exp=%b", bits, mk_frame(8'h3C)); end
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (tx_o !== 1'b1) lows++;
        end
        compared++; if (lows !== 0)       begin mismatched++; $display("[TB] FAIL en_second_held got=%0d low cycles exp=0", lows); end
        compared++; if (level_o !== 3'd1) begin mismatched++; $display("[TB] FAIL en_second_level got=%0d exp=1", level_o); end
        compared++; if (busy_o !== 1'b1)  begin mismatched++; $display("[TB] FAIL en_busy_queued got=%b exp=1", busy_o); end
        en_i = 1'b1;
        capture_frame(200, bits, w);
        compared++; if (w !== 1)                  begin mismatched++; $display("[TB] FAIL en_resume_latency got=%0d exp=1", w); end
        compared++; if (bits !== mk_frame(8'h55)) begin mismatched++; $display("[TB] FAIL en_resume_frame got=%b exp=%b", bits, mk_frame(8'h55)); end
        tick(4);
    endtask

    task automatic test_simul();
        logic [FRAME_BITS-1:0] bits;
        int w;
        en_i = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        compared++; if (level_o !== 3'd2) begin mismatched++; $display("[TB] FAIL simul_pre_level got=%0d exp=2", level_o); end
        en_i    = 1'b1;
        data_i  = 8'h33;
        valid_i = 1'b1;
        tick(1);
        valid_i = 1'b0;
        compared++; if (level_o !== 3'd2) begin mismatched++; $display("[TB] FAIL simul_level got=%0d exp=2", level_o); end
        compared++; if (tx_o !== 1'b0)    begin mismatched++; $display("[TB] FAIL simul_start got=%b exp=0", tx_o); end
        capture_frame(200, bits, w);
        compared++; if (bits !== mk_frame(8'h11)) begin mismatched++; $display("[TB] FAIL simul_frame_1 got=%b exp=%b", bits, mk_frame(8'h11)); end
        capture_frame(200, bits, w);
        compared++; if (w !== 2)                  begin mismatched++; $display("[TB] FAIL simul_gap_2 got=%0d exp=2", w); end
        compared++; if (bits !== mk_frame(8'h22)) begin mismatched++; $display("[TB] FAIL simul_frame_2 got=%b exp=%b", bits, mk_frame(8'h22)); end
        capture_frame(200, bits, w);
        compared++; if (w !== 2)                  begin mismatched++; $display("[TB] FAIL simul_gap_3 got=%0d exp=2", w); end
        compared++; if (bits !== mk_frame(8'h33)) begin mismatched++; $display("[TB] FAIL simul_frame_3 got=%b exp=%b", bits, mk_frame(8'h33)); end
        tick(2);
        compared++; if (busy_o !== 1'b0)  begin mismatched++; $display("[TB] FAIL simul_busy_drop got=%b exp=0", busy_o); end
    endtask

`ifdef HBIF_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [FRAME_BITS-1:0] bits;
        int w;
        en_i = 1'b1;
        push_byte(8'h07);
        push_byte(8'h03);
        capture_frame(200, bits, w);
        compared++; if (w !== 0)                     begin mismatched++; $display("[TB] FAIL parity_start got=%0d exp=0", w); end
        compared++; if (bits !== 11'b1_1_00000111_0) begin mismatched++; $display("[TB] FAIL parity_frame_07 got=%b exp=%b", bits, 11'b1_1_00000111_0); end
        capture_frame(200, bits, w);
        compared++; if (w !== 2)                     begin mismatched++; $display("[TB] FAIL parity_frame_len got=%0d exp=2", w); end
        compared++; if (bits !== 11'b1_0_00000011_0) begin mismatched++; $display("[TB] FAIL parity_frame_03 got=%b exp=%b", bits, 11'b1_0_00000011_0); end
        tick(1);
        compared++; if (busy_o !== 1'b1) begin mismatched++; $display("[TB] FAIL parity_busy_last got=%b exp=1", busy_o); end
        tick(1);
        compared++; if (busy_o !== 1'b0) begin mismatched++; $display("[TB] FAIL parity_busy_drop got=%b exp=0", busy_o); end
    endtask
`endif

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        test_reset();
        test_single();
        test_fill();
        test_enable();
        test_simul();
`ifdef HBIF_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
